// File: rtl/grf_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grf_mp: multi-port register file, 3 comb reads, 2 writes with bypass,      |
// | hardwired-zero r0, pending-write scoreboard. Optional macro: GRF_TRACE_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rbusy0,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [31:0]       pc0,
  input  logic [31:0]       pc1,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr
);

  localparam int C_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [C_DEPTH];
  logic [C_DEPTH-1:0] r_busy;

  logic              w_wr0;
  logic              w_wr1;
  logic              w_set;
  logic [ADDR_W-1:0] w_ra [3];
  logic [DATA_W-1:0] w_rd [3];
  logic [2:0]        w_rbusy;

  assign w_wr0 = we0 && (wa0 != '0);
  assign w_wr1 = we1 && (wa1 != '0);
  assign w_set = set_en && (set_addr != '0);

  // Port 1 is assigned last so it wins a collision; set after clear so set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
      if (w_wr0) r_busy[wa0] <= 1'b0;
      if (w_wr1) r_busy[wa1] <= 1'b0;
      if (w_set) r_busy[set_addr] <= 1'b1;
    end
  end

  assign w_ra[0] = ra0;
  assign w_ra[1] = ra1;
  assign w_ra[2] = ra2;

  generate
    for (genvar p = 0; p < 3; p++) begin : g_rd
      logic w_hit0;
      logic w_hit1;
      logic w_live;
      assign w_hit0 = we0 && (wa0 == w_ra[p]);
      assign w_hit1 = we1 && (wa1 == w_ra[p]);
      // Reads are forced to zero while reset is held, even against bypass data.
      assign w_live = reset && (w_ra[p] != '0);
      assign w_rd[p] = !w_live ? '0 :
                       w_hit1  ? wd1 :
                       w_hit0  ? wd0 : r_mem[w_ra[p]];
      assign w_rbusy[p] = w_live && r_busy[w_ra[p]] && !w_hit0 && !w_hit1;
    end
  endgenerate

  assign rd0    = w_rd[0];
  assign rd1    = w_rd[1];
  assign rd2    = w_rd[2];
  assign rbusy0 = w_rbusy[0];
  assign rbusy1 = w_rbusy[1];
  assign rbusy2 = w_rbusy[2];

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && we0) $display("@%h: $%d <= %h", pc0, wa0, wd0);
    if (reset && we1) $display("@%h: $%d <= %h", pc1, wa1, wd1);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{pc0, pc1};
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_grf_mp: vector table, hand-written async-reset sequence and randomized  |
// | cycles against a behavioural model of the register file.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_grf_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra0, ra1, ra2, wa0, wa1, set_addr;
  logic [DW-1:0] rd0, rd1, rd2, wd0, wd1;
  logic          rbusy0, rbusy1, rbusy2, we0, we1, set_en;
  logic [31:0]   pc0, pc1;

  int total = 0;
  int bad   = 0;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .ra1(ra1), .ra2(ra2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .rbusy0(rbusy0), .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .pc0(pc0), .pc1(pc1), .set_en(set_en), .set_addr(set_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          set_en;
    logic [AW-1:0] set_addr;
    logic [AW-1:0] ra0, ra1, ra2;
    logic [DW-1:0] e0, e1, e2;
    logic [2:0]    eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic w0, int a0, logic [31:0] d0,
                              logic w1, int a1, logic [31:0] d1, logic se, int sa,
                              int r0, int r1, int r2, logic [31:0] x0,
                              logic [31:0] x1, logic [31:0] x2, logic [2:0] b);
    vec_t v;
    v.rst = rst; v.we0 = w0; v.wa0 = AW'(a0); v.wd0 = d0;
    v.we1 = w1; v.wa1 = AW'(a1); v.wd1 = d1; v.set_en = se; v.set_addr = AW'(sa);
    v.ra0 = AW'(r0); v.ra1 = AW'(r1); v.ra2 = AW'(r2);
    v.e0 = x0; v.e1 = x1; v.e2 = x2; v.eb = b;
    return v;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; set_en = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; set_addr = '0;
  endtask

  task automatic chk_all(string tag, logic [DW-1:0] x0, logic [DW-1:0] x1,
                         logic [DW-1:0] x2, logic [2:0] b);
    chk({tag, ".rd0"}, rd0, x0);
    chk({tag, ".rd1"}, rd1, x1);
    chk({tag, ".rd2"}, rd2, x2);
    chk({tag, ".rbusy"}, {29'b0, rbusy2, rbusy1, rbusy0}, {29'b0, b});
  endtask

  logic [DW-1:0] m_mem [32];
  logic          m_busy[32];

  function automatic logic [DW-1:0] m_rd(logic rst, logic [AW-1:0] ra);
    if (!rst || ra == 0) return '0;
    if (we1 && wa1 == ra) return wd1;
    if (we0 && wa0 == ra) return wd0;
    return m_mem[ra];
  endfunction

  function automatic logic m_rb(logic rst, logic [AW-1:0] ra);
    if (!rst || ra == 0) return 1'b0;
    return m_busy[ra] && !(we0 && wa0 == ra) && !(we1 && wa1 == ra);
  endfunction

  initial begin
    reset = 0; pc0 = 32'h0; pc1 = 32'h0; ra0 = '0; ra1 = '0; ra2 = '0;
    idle();
    repeat (2) @(posedge clk);

    // One row per cycle: outputs checked before the edge that commits the row.
    vecs.push_back(mk(0, 1, 3, 32'hAAAA_0000, 0, 0, 0, 1, 3, 1, 2, 3, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 31, 2, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 5, 0, 6, 32'h1234_5678, 0, 0, 3'b000));
    vecs.push_back(mk(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 5, 0, 0, 32'h1234_5678, 0, 0, 3'b000));
    vecs.push_back(mk(1, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5, 0, 32'h22, 32'h1234_5678, 0, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 5, 32'h22, 32'h22, 32'h1234_5678, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 9, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 0, 0, 0, 3'b111));
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, 7, 32'h99, 0, 32'h22, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 32'h99, 32'h99, 32'h99, 3'b000));
    vecs.push_back(mk(1, 1, 9, 32'h55, 0, 0, 0, 1, 9, 9, 9, 9, 32'h55, 32'h55, 32'h55, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 32'h55, 32'h55, 32'h55, 3'b111));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 5, 0, 32'h55, 32'h1234_5678, 3'b010));
    vecs.push_back(mk(1, 1, 9, 32'h1, 1, 9, 32'h2, 0, 0, 9, 3, 9, 32'h2, 0, 32'h2, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 0, 32'h2, 0, 0, 3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      set_en = vecs[i].set_en; set_addr = vecs[i].set_addr;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].eb);
    end

    // Async reset between edges with live data and a pending busy bit.
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      idle();
      we0 = 1; wa0 = AW'(r); wd0 = 32'hC0DE_0000 + 32'(r);
      if (r == 4) begin set_en = 1; set_addr = AW'(6); end
    end
    @(negedge clk);
    idle(); we1 = 1; wa1 = AW'(11); wd1 = 32'hBEEF;
    set_en = 1; set_addr = AW'(4);
    @(negedge clk);
    idle(); ra0 = AW'(1); ra1 = AW'(4); ra2 = AW'(11);
    #1;
    chk_all("pre_rst", 32'hC0DE_0001, 32'hC0DE_0004, 32'hBEEF, 3'b010);
    @(posedge clk);
    #3;
    we0 = 1; wa0 = AW'(2); wd0 = 32'h7777; set_en = 1; set_addr = AW'(2);
    reset = 0;
    #1;
    ra2 = AW'(2);
    #0.1;
    chk_all("async_rst", 0, 0, 0, 3'b000);
    @(negedge clk);
    idle(); reset = 1; ra2 = AW'(2);
    #1;
    chk_all("post_rst", 0, 0, 0, 3'b000);
    @(posedge clk);
    #1;
    chk_all("post_rst_edge", 0, 0, 0, 3'b000);

    // Randomized cycles against the model; the first cycle forces a reset.
    for (int c = 0; c < 400; c++) begin
      logic [DW-1:0] x0, x1, x2;
      logic [2:0]    b;
      @(negedge clk);
      reset  = (c == 0) ? 1'b0 : ($urandom_range(0, 29) != 0);
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 2) == 0;
      wa0    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wa1    = AW'($urandom_range(0, 7));
      wd0    = $urandom;
      wd1    = $urandom;
      pc0    = $urandom;
      pc1    = $urandom;
      set_en = $urandom_range(0, 2) == 0;
      set_addr = AW'($urandom_range(0, 7));
      ra0    = AW'($urandom_range(0, 7));
      ra1    = AW'($urandom_range(0, 7));
      ra2    = AW'($urandom);
      if (!reset) begin
        for (int k = 0; k < 32; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
      end
      #1;
      x0 = m_rd(reset, ra0); x1 = m_rd(reset, ra1); x2 = m_rd(reset, ra2);
      b  = {m_rb(reset, ra2), m_rb(reset, ra1), m_rb(reset, ra0)};
      chk_all($sformatf("rnd%0d", c), x0, x1, x2, b);
      if (reset) begin
        if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
        if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
      end
    end

    @(negedge clk);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
